// File: rtl/score_display_arbiter.sv
// Two-player score display arbiter: keeps both scores, alternates which one is shown,
// detects the winner and blinks the display while the game is over.
module score_display_arbiter #(
    parameter int TICK_DIV   = 100000000,
    parameter int HOLD_TICKS = 3,
    parameter int WIN_SCORE  = 9
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_hit,
    input  logic       p2_hit,
    output logic [3:0] score,
    output logic [1:0] show_player,
    output logic       blank,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [3:0]    WIN_CNT    = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [PW-1:0] presc_r;
    logic          tick_s;
    logic [3:0]    p1_cnt_r, p1_cnt_nxt_s, p2_cnt_r, p2_cnt_nxt_s;
    logic [3:0]    p1_inc_s, p2_inc_s;
    logic          p1_win_s, p2_win_s;
    logic [HW-1:0] hold_r, hold_nxt_s;
    logic [1:0]    show_r, show_nxt_s;
    logic          blank_r, blank_nxt_s;
    logic          over_r, over_nxt_s;
    logic [1:0]    winner_r, winner_nxt_s;
    logic [3:0]    score_r, score_nxt_s;

    assign tick_s   = (presc_r == PRESC_LAST);
    assign p1_inc_s = p1_cnt_r + 4'd1;
    assign p2_inc_s = p2_cnt_r + 4'd1;
    assign p1_win_s = p1_hit && (p1_inc_s == WIN_CNT);
    assign p2_win_s = p2_hit && (p2_inc_s == WIN_CNT);

    // Next-state and next-output decode for the game FSM
    always_comb begin
        state_nxt_s  = state_r;
        p1_cnt_nxt_s = p1_cnt_r;
        p2_cnt_nxt_s = p2_cnt_r;
        hold_nxt_s   = hold_r;
        show_nxt_s   = show_r;
        blank_nxt_s  = blank_r;
        over_nxt_s   = over_r;
        winner_nxt_s = winner_r;
        if (start) begin
            state_nxt_s  = PLAY;
            p1_cnt_nxt_s = 4'd0;
            p2_cnt_nxt_s = 4'd0;
            hold_nxt_s   = HOLD_INIT;
            show_nxt_s   = 2'b01;
            blank_nxt_s  = 1'b0;
            over_nxt_s   = 1'b0;
            winner_nxt_s = 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                PLAY: begin
                    if (p1_hit || p2_hit) begin
                        if (p1_hit) begin
                            p1_cnt_nxt_s = p1_inc_s;
                        end else begin
                            p1_cnt_nxt_s = p1_cnt_r;
                        end
                        if (p2_hit) begin
                            p2_cnt_nxt_s = p2_inc_s;
                        end else begin
                            p2_cnt_nxt_s = p2_cnt_r;
                        end
                        hold_nxt_s = HOLD_INIT;
                        show_nxt_s = p1_hit ? 2'b01 : 2'b10;
                        // Reaching the winning score ends the game on this same edge
                        if (p1_win_s || p2_win_s) begin
                            state_nxt_s  = WIN;
                            over_nxt_s   = 1'b1;
                            winner_nxt_s = {p2_win_s, p1_win_s};
                            show_nxt_s   = p1_win_s ? 2'b01 : 2'b10;
                            blank_nxt_s  = 1'b0;
                        end else begin
                            state_nxt_s = PLAY;
                        end
                    end else if (tick_s) begin
                        if (hold_r <= HOLD_ONE) begin
                            hold_nxt_s = HOLD_INIT;
                            show_nxt_s = (show_r == 2'b01) ? 2'b10 : 2'b01;
                        end else begin
                            hold_nxt_s = hold_r - HOLD_ONE;
                        end
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                WIN: begin
                    if (tick_s) begin
                        blank_nxt_s = ~blank_r;
                    end else begin
                        blank_nxt_s = blank_r;
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    p1_cnt_nxt_s = 4'd0;
                    p2_cnt_nxt_s = 4'd0;
                    hold_nxt_s   = HOLD_INIT;
                    show_nxt_s   = 2'b00;
                    blank_nxt_s  = 1'b0;
                    over_nxt_s   = 1'b0;
                    winner_nxt_s = 2'b00;
                end
            endcase
        end
    end

    // Score mux follows the player that will be shown after this edge
    always_comb begin
        case (show_nxt_s)
            2'b01:   score_nxt_s = p1_cnt_nxt_s;
            2'b10:   score_nxt_s = p2_cnt_nxt_s;
            default: score_nxt_s = 4'd0;
        endcase
    end

    // State, prescaler, counters and output registers
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_r  <= IDLE;
            presc_r  <= '0;
            p1_cnt_r <= 4'd0;
            p2_cnt_r <= 4'd0;
            hold_r   <= HOLD_INIT;
            show_r   <= 2'b00;
            blank_r  <= 1'b0;
            over_r   <= 1'b0;
            winner_r <= 2'b00;
            score_r  <= 4'd0;
        end else begin
            if (start || tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
            end
            state_r  <= state_nxt_s;
            p1_cnt_r <= p1_cnt_nxt_s;
            p2_cnt_r <= p2_cnt_nxt_s;
            hold_r   <= hold_nxt_s;
            show_r   <= show_nxt_s;
            blank_r  <= blank_nxt_s;
            over_r   <= over_nxt_s;
            winner_r <= winner_nxt_s;
            score_r  <= score_nxt_s;
        end
    end

    assign score       = score_r;
    assign show_player = show_r;
    assign blank       = blank_r;
    assign game_over   = over_r;
    assign winner      = winner_r;

endmodule

// File: tb/tb_score_display_arbiter.sv
// Randomized bench for score_display_arbiter, checked every cycle against a
// behavioural game model (elapsed-cycle tick timing, ticks-since-reload alternation).
module tb_score_display_arbiter;

    localparam int TD = 4;
    localparam int HT = 2;
    localparam int WS = 3;

    logic       clock_100Mhz = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic [3:0] score;
    logic [1:0] show_player;
    logic       blank;
    logic       game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0 idle, 1 play, 2 win
    int m_mode = 0, m_el = 0, m_c1 = 0, m_c2 = 0, m_quiet = 0;
    int m_show = 0, m_blank = 0, m_over = 0, m_win = 0;

    score_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT), .WIN_SCORE(WS)) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset(reset),
        .start(start),
        .p1_hit(p1_hit),
        .p2_hit(p2_hit),
        .score(score),
        .show_player(show_player),
        .blank(blank),
        .game_over(game_over),
        .winner(winner)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit a, input bit b);
        bit tick;
        tick = ((m_el % TD) == TD - 1);
        if (r) begin
            m_mode = 0; m_el = 0; m_c1 = 0; m_c2 = 0; m_quiet = 0;
            m_show = 0; m_blank = 0; m_over = 0; m_win = 0;
        end else begin
            m_el = s ? 0 : m_el + 1;
            if (s) begin
                m_mode = 1; m_c1 = 0; m_c2 = 0; m_quiet = 0;
                m_show = 1; m_blank = 0; m_over = 0; m_win = 0;
            end else if (m_mode == 1) begin
                if (a || b) begin
                    m_c1 += int'(a);
                    m_c2 += int'(b);
                    m_quiet = 0;
                    m_show = a ? 1 : 2;
                    if (m_c1 == WS || m_c2 == WS) begin
                        m_mode = 2;
                        m_over = 1;
                        m_blank = 0;
                        m_win = (m_c1 == WS && m_c2 == WS) ? 3 : (m_c1 == WS ? 1 : 2);
                        m_show = (m_c1 == WS) ? 1 : 2;
                    end
                end else if (tick) begin
                    m_quiet++;
                    if (m_quiet == HT) begin
                        m_show = 3 - m_show;
                        m_quiet = 0;
                    end
                end
            end else if (m_mode == 2 && tick) begin
                m_blank = 1 - m_blank;
            end
        end
    endtask

    function automatic int exp_score();
        return (m_show == 1) ? m_c1 : ((m_show == 2) ? m_c2 : 0);
    endfunction

    task automatic cycle(input bit r, input bit s, input bit a, input bit b);
        reset = r; start = s; p1_hit = a; p2_hit = b;
        model_step(r, s, a, b);
        @(posedge clock_100Mhz);
        #1;
        reset = 1'b0; start = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0;
        check("score", 32'(score), 32'(exp_score()));
        check("show_player", 32'(show_player), 32'(m_show));
        check("blank", 32'(blank), 32'(m_blank));
        check("game_over", 32'(game_over), 32'(m_over));
        check("winner", 32'(winner), 32'(m_win));
    endtask

    initial begin
        bit r, s, a, b;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_show", 32'(show_player), 32'd0);

        // hits ignored while idle
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_score", 32'(score), 32'd0);
        check("idle_show", 32'(show_player), 32'd0);

        // free-running alternation over 8 ticks
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("start_show", 32'(show_player), 32'd1);
        repeat (8 * TD) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // single p2 hit, then a hit landing on a tick
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("p2_hit_score", 32'(score), 32'd1);
        check("p2_hit_show", 32'(show_player), 32'd2);
        for (int i = 0; i < TD && (m_el % TD) != TD - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("hit_on_tick_show", 32'(show_player), 32'd2);
        repeat (3 * TD) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // tie game
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("tie_over", 32'(game_over), 32'd1);
        check("tie_winner", 32'(winner), 32'd3);
        check("tie_show", 32'(show_player), 32'd1);
        check("tie_score", 32'(score), 32'd3);
        repeat (3 * TD) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // p1 wins, later hits ignored, restart
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("p1_winner", 32'(winner), 32'd1);
        check("p1_win_score", 32'(score), 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("win_frozen", 32'(score), 32'd3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("restart_show", 32'(show_player), 32'd1);
        check("restart_score", 32'(score), 32'd0);
        check("restart_over", 32'(game_over), 32'd0);

        // reset mid-game
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("midreset_score", 32'(score), 32'd0);
        check("midreset_show", 32'(show_player), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("post_reset_idle", 32'(show_player), 32'd0);

        // randomized play
        repeat (3000) begin
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 5) == 0);
            cycle(r, s, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
